// File: rtl/bp_be_pkg.sv
// Back-end shared definitions for the MMU command arbiter slice.
//   - bp_params_e            : processor configuration selector
//   - bp_vaddr_width() etc.  : per-configuration geometry lookups
//   - bp_be_mmu_arb_state_e  : pipe-buffer arbitration state
//   - `BP_BE_MMU_CMD_WIDTH   : packed width of one MMU command
//   - `DECLARE_BP_BE_MMU_STRUCTS : declares bp_be_mmu_cmd_s in the caller's scope
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

// One MMU command is {mem_op[3:0], vaddr, data[63:0]}.
`define BP_BE_MMU_CMD_WIDTH(vaddr_width_mp) (4 + (vaddr_width_mp) + 64)

`define DECLARE_BP_BE_MMU_STRUCTS(vaddr_width_mp) \
  typedef struct packed {                          \
    logic [3:0]                mem_op;             \
    logic [(vaddr_width_mp)-1:0] vaddr;            \
    logic [63:0]               data;               \
  } bp_be_mmu_cmd_s;

package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg,
    e_bp_sv48_cfg
  } bp_params_e;

  typedef enum logic [1:0] {
    e_empty,
    e_hold,
    e_starved
  } bp_be_mmu_arb_state_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    return (cfg == e_bp_sv48_cfg) ? 48 : 39;
  endfunction

  function automatic int bp_ppn_width(bp_params_e cfg);
    return (cfg == e_bp_sv48_cfg) ? 36 : 28;
  endfunction

  function automatic int bp_lce_sets(bp_params_e cfg);
    return (cfg == e_bp_sv48_cfg) ? 128 : 64;
  endfunction

  function automatic int bp_cce_block_width(bp_params_e cfg);
    return (cfg == e_bp_sv48_cfg) ? 512 : 512;
  endfunction

endpackage

`endif

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset to zero.
//   clk_i   : clock
//   reset_i : synchronous reset, clears the stored word
//   en_i    : load data_i on the rising edge when high
//   data_i  : next value
//   data_o  : stored value
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  // Reset has priority over the load enable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_be_mmu_cmd_arb.sv
// Arbitrates between the memory pipe and the page-table walker for the MMU.
// The pipe command is captured in a one-entry buffer (latency 1); the PTW
// command passes straight through (latency 0) and normally wins. A buffered
// pipe command that keeps losing is promoted once it has lost starve_limit_p
// cycles, after which it beats the PTW for one grant.
//   clk_i / reset_i          : clock, synchronous active-high reset
//   flush_i                  : kills the buffered pipe command
//   pipe_cmd_i/_v_i/_ready_o : pipe command handshake
//   ptw_cmd_i/_v_i/_ready_o  : PTW command handshake
//   mmu_cmd_o/_v_o/_ready_i  : selected command towards the MMU
//   grant_ptw_o              : mmu_cmd_o currently carries the PTW command
//   busy_o                   : pipe buffer occupied
module bp_be_mmu_cmd_arb
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_inv_cfg,
  parameter int         starve_limit_p = 4,
  localparam int vaddr_width_p    = bp_vaddr_width(bp_params_p),
  localparam int mmu_cmd_width_lp = `BP_BE_MMU_CMD_WIDTH(vaddr_width_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,

  input  logic [mmu_cmd_width_lp-1:0] pipe_cmd_i,
  input  logic                        pipe_cmd_v_i,
  output logic                        pipe_cmd_ready_o,

  input  logic [mmu_cmd_width_lp-1:0] ptw_cmd_i,
  input  logic                        ptw_cmd_v_i,
  output logic                        ptw_cmd_ready_o,

  output logic [mmu_cmd_width_lp-1:0] mmu_cmd_o,
  output logic                        mmu_cmd_v_o,
  input  logic                        mmu_cmd_ready_i,

  output logic                        grant_ptw_o,
  output logic                        busy_o
);

  `DECLARE_BP_BE_MMU_STRUCTS(vaddr_width_p)

  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0] starve_max_lp = cnt_w_lp'(starve_limit_p);

  logic [mmu_cmd_width_lp-1:0] pipe_q;
  logic                        pipe_v_q, pipe_v_d;
  logic                        pipe_accept, pipe_fire, pipe_en;
  logic                        pipe_eligible, grant_ptw, grant_pipe;
  logic [cnt_w_lp-1:0]         starve_cnt_q, starve_cnt_d;
  bp_be_mmu_arb_state_e        state_q, state_d;
  bp_be_mmu_cmd_s              mmu_cmd_sel;

  // Reset is treated like a flush on the pipe side so a command that is about
  // to be discarded never completes an MMU handshake or gets accepted.
  assign pipe_eligible = pipe_v_q & ~flush_i & ~reset_i;

  // PTW wins unless the pipe command has been starved.
  assign grant_ptw  = ptw_cmd_v_i & ((state_q != e_starved) | ~pipe_eligible);
  assign grant_pipe = pipe_eligible & ~grant_ptw;
  assign pipe_fire  = grant_pipe & mmu_cmd_ready_i;

  // Draining and refilling the buffer in the same cycle keeps 1 cmd/cycle.
  assign pipe_cmd_ready_o = (~pipe_v_q | pipe_fire) & ~flush_i & ~reset_i;
  assign pipe_accept      = pipe_cmd_v_i & pipe_cmd_ready_o;
  assign pipe_v_d         = pipe_accept | (pipe_v_q & ~pipe_fire & ~flush_i);
  assign pipe_en          = pipe_accept | pipe_fire | flush_i;

  bsg_dff_reset_en #(
    .width_p (mmu_cmd_width_lp + 1)
  ) pipe_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (pipe_en),
    .data_i  ({pipe_v_d, (pipe_accept ? pipe_cmd_i : pipe_q)}),
    .data_o  ({pipe_v_q, pipe_q})
  );

  // The counter restarts for every newly buffered command and saturates.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (flush_i | pipe_fire | ~pipe_v_q) begin
      starve_cnt_d = '0;
    end else if (~grant_pipe && (starve_cnt_q != starve_max_lp)) begin
      starve_cnt_d = starve_cnt_q + cnt_w_lp'(1);
    end
  end

  always_comb begin
    state_d = e_hold;
    if (~pipe_v_d) begin
      state_d = e_empty;
    end else if (starve_cnt_d == starve_max_lp) begin
      state_d = e_starved;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_empty;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign mmu_cmd_sel     = grant_ptw ? ptw_cmd_i : pipe_q;
  assign mmu_cmd_o       = mmu_cmd_sel;
  assign mmu_cmd_v_o     = grant_ptw | grant_pipe;
  assign grant_ptw_o     = grant_ptw;
  assign ptw_cmd_ready_o = grant_ptw & mmu_cmd_ready_i;
  assign busy_o          = pipe_v_q;

endmodule

// File: tb/tb_bp_be_mmu_cmd_arb.sv
// Directed bench for bp_be_mmu_cmd_arb. Every cycle the expected control
// outputs are given by hand; pipe commands that should be accepted are pushed
// into a queue and popped when the MMU takes a pipe command.
module tb_bp_be_mmu_cmd_arb;
  import bp_be_pkg::*;

  localparam int vaW  = bp_vaddr_width(e_bp_inv_cfg);
  localparam int cmdW = `BP_BE_MMU_CMD_WIDTH(vaW);

  logic            clk = 1'b0;
  logic            reset_i, flush_i;
  logic [cmdW-1:0] pipe_cmd_i, ptw_cmd_i, mmu_cmd_o;
  logic            pipe_cmd_v_i, pipe_cmd_ready_o;
  logic            ptw_cmd_v_i, ptw_cmd_ready_o;
  logic            mmu_cmd_v_o, mmu_cmd_ready_i;
  logic            grant_ptw_o, busy_o;

  logic [cmdW-1:0] pipeQ[$];
  logic [cmdW-1:0] ptwCmdExp;
  int              nAssert = 0;
  int              nFail   = 0;
  int              pipeFires = 0;

  bp_be_mmu_cmd_arb #(
    .bp_params_p    (e_bp_inv_cfg),
    .starve_limit_p (4)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .flush_i          (flush_i),
    .pipe_cmd_i       (pipe_cmd_i),
    .pipe_cmd_v_i     (pipe_cmd_v_i),
    .pipe_cmd_ready_o (pipe_cmd_ready_o),
    .ptw_cmd_i        (ptw_cmd_i),
    .ptw_cmd_v_i      (ptw_cmd_v_i),
    .ptw_cmd_ready_o  (ptw_cmd_ready_o),
    .mmu_cmd_o        (mmu_cmd_o),
    .mmu_cmd_v_o      (mmu_cmd_v_o),
    .mmu_cmd_ready_i  (mmu_cmd_ready_i),
    .grant_ptw_o      (grant_ptw_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  // Builds a recognisable command from a virtual address.
  function automatic logic [cmdW-1:0] mkCmd(input logic [31:0] va);
    logic [cmdW-1:0] c;
    c = '0;
    c[cmdW-1 -: 4] = 4'h3;
    c[64 +: vaW]   = vaW'(va);
    c[63:0]        = 64'(va) * 64'd3;
    return c;
  endfunction

  task automatic checkBit(input string tag, input logic got, input logic exp);
    nAssert++;
    assert (got === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic checkCmd(input string tag, input logic [cmdW-1:0] got, input logic [cmdW-1:0] exp);
    nAssert++;
    assert (got === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] pva,
                               input logic tv, input logic [31:0] tva,
                               input logic rdy, input logic fl, input logic rst);
    pipe_cmd_v_i    = pv;
    pipe_cmd_i      = mkCmd(pva);
    ptw_cmd_v_i     = tv;
    ptw_cmd_i       = mkCmd(tva);
    ptwCmdExp       = mkCmd(tva);
    mmu_cmd_ready_i = rdy;
    flush_i         = fl;
    reset_i         = rst;
  endtask

  // Samples at the falling edge; pops the scoreboard on a pipe-side fire,
  // then pushes a command the bench expects to be accepted this cycle.
  task automatic checkOutput(input string tag, input logic expV, input logic expG,
                             input logic expPrdy, input logic expTrdy, input logic expBusy);
    logic [cmdW-1:0] expCmd;
    @(negedge clk);
    checkBit({tag, ".mmu_v"},      mmu_cmd_v_o,      expV);
    checkBit({tag, ".grant_ptw"},  grant_ptw_o,      expG);
    checkBit({tag, ".pipe_ready"}, pipe_cmd_ready_o, expPrdy);
    checkBit({tag, ".ptw_ready"},  ptw_cmd_ready_o,  expTrdy);
    checkBit({tag, ".busy"},       busy_o,           expBusy);
    if (mmu_cmd_v_o === 1'b1 && mmu_cmd_ready_i) begin
      if (grant_ptw_o === 1'b1) begin
        checkCmd({tag, ".ptw_cmd"}, mmu_cmd_o, ptwCmdExp);
      end else begin
        nAssert++;
        assert (pipeQ.size() != 0)
        else begin
          nFail++;
          $error("[TB] FAIL %s.sb_empty: observed unexpected pipe fire, expected none", tag);
        end
        if (pipeQ.size() != 0) begin
          expCmd = pipeQ.pop_front();
          checkCmd({tag, ".pipe_cmd"}, mmu_cmd_o, expCmd);
          pipeFires++;
        end
      end
    end
    if (expPrdy && pipe_cmd_v_i) pipeQ.push_back(pipe_cmd_i);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runStep(input string tag,
                         input logic pv, input logic [31:0] pva,
                         input logic tv, input logic [31:0] tva,
                         input logic rdy, input logic fl,
                         input logic expV, input logic expG, input logic expPrdy,
                         input logic expTrdy, input logic expBusy);
    applyStimulus(pv, pva, tv, tva, rdy, fl, 1'b0);
    checkOutput(tag, expV, expG, expPrdy, expTrdy, expBusy);
    nextCycle();
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset released");

    runStep("reset", 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0);

    // Single pipe command, latency 1.
    runStep("A0", 1, 'h1000, 0, 0, 1, 0,  0, 0, 1, 0, 0);
    runStep("A1", 0, 0,      0, 0, 1, 0,  1, 0, 1, 0, 1);
    runStep("A2", 0, 0,      0, 0, 1, 0,  0, 0, 1, 0, 0);

    // Back-to-back pipe commands.
    for (int i = 0; i < 8; i++) begin
      runStep($sformatf("B%0d", i), 1, 32'h2000 + 32'(i * 8), 0, 0, 1, 0,
              (i != 0), 0, 1, 0, (i != 0));
    end
    runStep("B8", 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 1);
    runStep("B9", 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0);

    // Starvation: PTW wins four cycles, then the pipe command goes.
    runStep("C0", 1, 'h3000, 0, 0, 1, 0,  0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      runStep($sformatf("C%0d", i), 0, 0, 1, 32'h8000 + 32'(i), 1, 0,  1, 1, 0, 1, 1);
    end
    runStep("C5", 0, 0,      1, 'h8005, 1, 0,  1, 0, 1, 0, 1);
    runStep("C6", 1, 'h3100, 1, 'h8006, 1, 0,  1, 1, 1, 1, 0);
    for (int i = 7; i <= 10; i++) begin
      runStep($sformatf("C%0d", i), 0, 0, 1, 32'h8000 + 32'(i), 1, 0,  1, 1, 0, 1, 1);
    end
    runStep("C11", 0, 0, 1, 'h800b, 1, 0,  1, 0, 1, 0, 1);
    runStep("C12", 0, 0, 0, 0,      1, 0,  0, 0, 1, 0, 0);

    // Flush of a stalled pipe command; flush leaves PTW alone.
    runStep("D0", 1, 'h4000, 0, 0, 1, 0,  0, 0, 1, 0, 0);
    runStep("D1", 0, 0,      0, 0, 0, 0,  1, 0, 0, 0, 1);
    runStep("D2", 0, 0,      0, 0, 0, 1,  0, 0, 0, 0, 1);
    pipeQ.delete();
    runStep("D3", 0, 0, 1, 'h8100, 1, 1,  1, 1, 0, 1, 0);
    runStep("D4", 0, 0, 0, 0,      1, 0,  0, 0, 1, 0, 0);

    // Reset while starved with PTW pending.
    runStep("E0", 1, 'h5000, 0, 0, 1, 0,  0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      runStep($sformatf("E%0d", i), 0, 0, 1, 32'h8200 + 32'(i), 1, 0,  1, 1, 0, 1, 1);
    end
    applyStimulus(0, 0, 1, 'h8205, 0, 0, 1);
    nextCycle();
    pipeQ.delete();
    runStep("E6", 0, 0, 1, 'h8206, 1, 0,  1, 1, 1, 1, 0);
    runStep("E7", 0, 0, 0, 0,      1, 0,  0, 0, 1, 0, 0);

    // Simultaneous PTW and pipe into an empty buffer.
    runStep("F0", 1, 'h6000, 1, 'h8300, 1, 0,  1, 1, 1, 1, 0);
    runStep("F1", 0, 0,      0, 0,      1, 0,  1, 0, 1, 0, 1);
    runStep("F2", 0, 0,      0, 0,      1, 0,  0, 0, 1, 0, 0);

    // Stalled PTW holds its grant while a pipe command is buffered.
    runStep("G0", 1, 'h7000, 1, 'h8400, 0, 0,  1, 1, 1, 0, 0);
    runStep("G1", 0, 0,      1, 'h8400, 0, 0,  1, 1, 0, 0, 1);
    runStep("G2", 0, 0,      0, 0,      1, 0,  1, 0, 1, 0, 1);
    runStep("G3", 0, 0,      0, 0,      1, 0,  0, 0, 1, 0, 0);

    nAssert++;
    assert (pipeQ.size() == 0)
    else begin
      nFail++;
      $error("[TB] FAIL sb_leftover: observed %0d pending, expected 0", pipeQ.size());
    end
    nAssert++;
    assert (pipeFires == 13)
    else begin
      nFail++;
      $error("[TB] FAIL pipe_fire_count: observed %0d expected 13", pipeFires);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
